// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter with three per-source circular FIFOs
// (mult, alu, st). One FIFO head is broadcast per cycle on cdb_out. A branch
// squash invalidates buffered speculative entries, which are then drained
// silently without ever reaching the bus.
// Optional feature: define CDB_RR_ARB_EN for round-robin arbitration; the
// default build uses fixed priority mult > alu > st.
// Handshake: x_stall is high when source x's FIFO is full; the producer must
// hold x_in.valid low while x_stall is high. cdb_out is a valid-qualified
// broadcast with no back-pressure: a packet shown with valid=1 is consumed
// at the next rising clock edge.

package cdb_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [4:0]  rob_tag;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        spec;
  } ex_wr_packet;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  ex_wr_packet alu_in,
  input  ex_wr_packet st_in,
  input  ex_wr_packet mult_in,
  input  logic        squash,
  output logic        alu_stall,
  output logic        st_stall,
  output logic        mult_stall,
  output ex_wr_packet cdb_out
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int NSRC = 3;

  // Source index: 0 = mult, 1 = alu, 2 = st (also the round-robin encoding).
  ex_wr_packet   mem   [NSRC][FIFO_DEPTH];
  logic [PW-1:0] head  [NSRC];
  logic [PW-1:0] tail  [NSRC];
  logic [CW-1:0] count [NSRC];

  ex_wr_packet   src_in   [NSRC];
  ex_wr_packet   head_pkt [NSRC];
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] silent_deq;
  logic [NSRC-1:0] grant_deq;
  logic [NSRC-1:0] enq;
  logic [NSRC-1:0] deq;

  logic        grant_found;
  logic [1:0]  grant_src;
  ex_wr_packet grant_pkt;
  logic        grant_fire;

  assign src_in[0] = mult_in;
  assign src_in[1] = alu_in;
  assign src_in[2] = st_in;

  // Per-FIFO status: head view, full flag, eligibility, silent drain, enqueue.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      head_pkt[s]   = mem[s][head[s]];
      full[s]       = (count[s] == CW'(FIFO_DEPTH));
      eligible[s]   = (count[s] != '0) && head_pkt[s].valid;
      silent_deq[s] = (count[s] != '0) && !head_pkt[s].valid;
      // Speculative arrivals during a squash belong to the flushed path.
      enq[s]        = src_in[s].valid && !full[s] && !(squash && src_in[s].spec);
    end
  end

`ifdef CDB_RR_ARB_EN
  logic [1:0] rr_ptr;
  logic [1:0] cand [NSRC];

  function automatic logic [1:0] next_src(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin search starting just after the last granted source.
  always_comb begin
    grant_found = 1'b0;
    grant_src   = 2'd0;
    cand[0]     = next_src(rr_ptr);
    cand[1]     = next_src(cand[0]);
    cand[2]     = next_src(cand[1]);
    for (int k = 0; k < NSRC; k++) begin
      if (!grant_found && eligible[cand[k]]) begin
        grant_found = 1'b1;
        grant_src   = cand[k];
      end
    end
  end

  // Remember the last source that actually broadcast.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 2'd0;
    end else if (grant_fire) begin
      rr_ptr <= grant_src;
    end
  end
`else
  // Fixed priority: mult, then alu, then st.
  always_comb begin
    grant_found = 1'b1;
    grant_src   = 2'd0;
    if (eligible[0]) begin
      grant_src = 2'd0;
    end else if (eligible[1]) begin
      grant_src = 2'd1;
    end else if (eligible[2]) begin
      grant_src = 2'd2;
    end else begin
      grant_found = 1'b0;
    end
  end
`endif

  // Grant qualification, bus drive and dequeue selection.
  always_comb begin
    grant_pkt  = head_pkt[grant_src];
    // A speculative head seen during a squash is neither broadcast nor popped;
    // it is invalidated at this edge and drained silently afterwards.
    grant_fire = grant_found && !(squash && grant_pkt.spec);
    cdb_out    = '0;
    if (grant_fire && !reset) begin
      cdb_out = grant_pkt;
    end
    for (int s = 0; s < NSRC; s++) begin
      grant_deq[s] = grant_fire && (grant_src == 2'(s));
      deq[s]       = grant_deq[s] || silent_deq[s];
    end
    mult_stall = full[0] && !reset;
    alu_stall  = full[1] && !reset;
    st_stall   = full[2] && !reset;
  end

  // FIFO storage, pointers and occupancy counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NSRC; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem[s][e] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        // Invalidate first so a same-edge enqueue into a free slot wins.
        if (squash) begin
          for (int e = 0; e < FIFO_DEPTH; e++) begin
            if (mem[s][e].spec) begin
              mem[s][e].valid <= 1'b0;
            end
          end
        end
        if (enq[s]) begin
          mem[s][tail[s]] <= src_in[s];
          tail[s]         <= tail[s] + PW'(1);
        end
        if (deq[s]) begin
          head[s] <= head[s] + PW'(1);
        end
        if (enq[s] && !deq[s]) begin
          count[s] <= count[s] + CW'(1);
        end else if (!enq[s] && deq[s]) begin
          count[s] <= count[s] - CW'(1);
        end
      end
    end
  end

  // A producer must not present a packet while its FIFO is full.
  a_alu_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(alu_in.valid && full[1]))
    else $error("cdb_arbiter: alu packet dropped, FIFO full");
  a_st_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(st_in.valid && full[2]))
    else $error("cdb_arbiter: st packet dropped, FIFO full");
  a_mult_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(mult_in.valid && full[0]))
    else $error("cdb_arbiter: mult packet dropped, FIFO full");

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic for cdb_arbiter,
// checked every cycle against a queue-based model of the bus rules.
// Build with +define+CDB_RR_ARB_EN to exercise the round-robin variant.

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = 2;
`ifdef CDB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  ex_wr_packet alu_in;
  ex_wr_packet st_in;
  ex_wr_packet mult_in;
  logic        squash;
  logic        alu_stall;
  logic        st_stall;
  logic        mult_stall;
  ex_wr_packet cdb_out;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];

  cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .alu_in     (alu_in),
    .st_in      (st_in),
    .mult_in    (mult_in),
    .squash     (squash),
    .alu_stall  (alu_stall),
    .st_stall   (st_stall),
    .mult_stall (mult_stall),
    .cdb_out    (cdb_out)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ex_wr_packet mk(input int tag, input int val, input bit spec);
    ex_wr_packet p;
    p.valid   = 1'b1;
    p.value   = 32'(val);
    p.rob_tag = 5'(tag);
    p.inst    = $urandom;
    p.npc     = $urandom;
    p.spec    = spec;
    return p;
  endfunction

  function automatic ex_wr_packet src_pkt(input int s);
    case (s)
      0:       return mult_in;
      1:       return alu_in;
      default: return st_in;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_in  = '0;
    st_in   = '0;
    mult_in = '0;
    squash  = 1'b0;
  endtask

  // Reference model: one queue per source, entries carry their own valid bit.
  ex_wr_packet mq [3][$];
  int last_src = 0;

  always @(negedge clock) begin : cmp
    ex_wr_packet exp_cdb;
    ex_wr_packet inp;
    ex_wr_packet tmp;
    logic [2:0]  exp_stall;
    logic [2:0]  was_full;
    logic [2:0]  silent;
    int          g;
    int          c;
    bit          fire;

    exp_cdb = '0;
    g       = -1;
    fire    = 1'b0;
    for (int s = 0; s < 3; s++) begin
      was_full[s]  = (mq[s].size() == DEPTH);
      exp_stall[s] = !reset && was_full[s];
      silent[s]    = (mq[s].size() > 0) && !mq[s][0].valid;
    end
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        c = RR ? (last_src + 1 + k) % 3 : k;
        if (g < 0 && mq[c].size() > 0 && mq[c][0].valid) g = c;
      end
      if (g >= 0) begin
        fire = !(squash && mq[g][0].spec);
        if (fire) exp_cdb = mq[g][0];
      end
    end

    chk("cdb_out", 128'(cdb_out), 128'(exp_cdb));
    chk("stalls", 128'({mult_stall, alu_stall, st_stall}),
        128'({exp_stall[0], exp_stall[1], exp_stall[2]}));

    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
      last_src = 0;
    end else begin
      if (fire) begin
        void'(mq[g].pop_front());
        last_src = g;
      end
      for (int s = 0; s < 3; s++) begin
        if (silent[s]) void'(mq[s].pop_front());
        if (squash) begin
          for (int i = 0; i < mq[s].size(); i++) begin
            tmp = mq[s][i];
            if (tmp.spec) tmp.valid = 1'b0;
            mq[s][i] = tmp;
          end
        end
        inp = src_pkt(s);
        if (inp.valid && !was_full[s] && !(squash && inp.spec)) mq[s].push_back(inp);
      end
    end
  end

  // Stimulus and directed expectations
  initial begin : main
    logic [4:0] order [3];
    int seen1;
    int seen2;
    int sent;
    bit saw_full;

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single ALU packet: visible the cycle after enqueue, gone the cycle after.
    alu_in = mk(3, 5, 1'b0);
    @(negedge clock);
    chk("s1_pre_idle", 128'(cdb_out), 128'(0));
    cyc();
    alu_in = '0;
    @(negedge clock);
    chk("s1_valid", 128'(cdb_out.valid), 128'(1));
    chk("s1_value", 128'(cdb_out.value), 128'(5));
    chk("s1_tag", 128'(cdb_out.rob_tag), 128'(3));
    cyc();
    @(negedge clock);
    chk("s1_idle", 128'(cdb_out.valid), 128'(0));

    // All three sources in the same cycle, from a fresh reset.
    cyc();
    reset = 1'b1;
    cyc();
    reset   = 1'b0;
    mult_in = mk(10, 100, 1'b0);
    alu_in  = mk(11, 101, 1'b0);
    st_in   = mk(12, 102, 1'b0);
    cyc();
    idle_inputs();
    if (RR) begin
      order[0] = 5'd11; order[1] = 5'd12; order[2] = 5'd10;
    end else begin
      order[0] = 5'd10; order[1] = 5'd11; order[2] = 5'd12;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("s2_valid", 128'(cdb_out.valid), 128'(1));
      chk("s2_order", 128'(cdb_out.rob_tag), 128'(order[i]));
      cyc();
    end
    @(negedge clock);
    chk("s2_idle", 128'(cdb_out.valid), 128'(0));

    // Mult stream for 4 cycles while alu and st flood.
    for (int i = 0; i < 4; i++) begin
      cyc();
      mult_in = mk(13 + i, i, 1'b0);
      alu_in  = alu_stall ? '0 : mk(17 + i, i, 1'b0);
      st_in   = st_stall ? '0 : mk(21 + i, i, 1'b0);
      @(negedge clock);
`ifndef CDB_RR_ARB_EN
      chk("s3_mult_stall", 128'(mult_stall), 128'(0));
      chk("s3_alu_stall", 128'(alu_stall), 128'(i >= 2));
`endif
    end
    cyc();
    idle_inputs();
    repeat (10) cyc();

    // Squash with ALU holding a committed and a speculative entry.
    seen1 = 0;
    seen2 = 0;
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      if (i == 0) begin
        alu_in  = mk(1, 7, 1'b0);
        mult_in = mk(30, 8, 1'b0);
      end else if (i == 1) begin
        alu_in  = mk(2, 9, 1'b1);
        mult_in = mk(31, 10, 1'b0);
      end else if (i == 2) begin
        squash = 1'b1;
      end
      @(negedge clock);
      if (cdb_out.valid && cdb_out.rob_tag == 5'd1) seen1++;
      if (cdb_out.valid && cdb_out.rob_tag == 5'd2) seen2++;
      cyc();
    end
    chk("s4_tag1_once", 128'(seen1), 128'(1));
    chk("s4_tag2_never", 128'(seen2), 128'(0));
    idle_inputs();

    // Six ALU packets through a depth-2 FIFO, partly blocked by mult traffic.
    sent     = 0;
    saw_full = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      if (sent == 6 && exp_q.size() == 0) break;
      if (alu_stall) saw_full = 1'b1;
      if (sent < 6 && !alu_stall) begin
        alu_in = mk(20 + sent, 200 + sent, 1'b0);
        exp_q.push_back(5'(20 + sent));
        sent++;
      end else begin
        alu_in = '0;
      end
      mult_in = (i < 4) ? mk(8 + i, i, 1'b0) : '0;
      @(negedge clock);
      if (cdb_out.valid && cdb_out.rob_tag >= 5'd20 && cdb_out.rob_tag <= 5'd25) begin
        if (exp_q.size() == 0) begin
          chk("s5_extra", 128'(cdb_out.rob_tag), 128'(0));
        end else begin
          chk("s5_order", 128'(cdb_out.rob_tag), 128'(exp_q.pop_front()));
        end
      end
      cyc();
    end
    chk("s5_all_out", 128'(exp_q.size()), 128'(0));
    chk("s5_sent", 128'(sent), 128'(6));
`ifndef CDB_RR_ARB_EN
    chk("s5_saw_full", 128'(saw_full), 128'(1));
`endif
    idle_inputs();

    // Fill every FIFO, then reset mid-operation.
    for (int i = 0; i < 6; i++) begin
      mult_in = mult_stall ? '0 : mk(i, i, 1'b0);
      alu_in  = alu_stall ? '0 : mk(i + 6, i, 1'b0);
      st_in   = st_stall ? '0 : mk(i + 12, i, 1'b0);
      cyc();
    end
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    chk("s6_rst_cdb", 128'(cdb_out), 128'(0));
    chk("s6_rst_stall", 128'({mult_stall, alu_stall, st_stall}), 128'(0));
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("s6_post_cdb", 128'(cdb_out.valid), 128'(0));
    chk("s6_post_stall", 128'({mult_stall, alu_stall, st_stall}), 128'(0));
    cyc();
    @(negedge clock);
    chk("s6_post2_cdb", 128'(cdb_out.valid), 128'(0));

    // Randomized traffic with occasional squash and reset.
    for (int i = 0; i < 600; i++) begin
      cyc();
      reset  = ($urandom_range(0, 99) == 0);
      squash = ($urandom_range(0, 9) == 0);
      mult_in = (!mult_stall && $urandom_range(0, 1) == 1)
                ? mk($urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1))) : '0;
      alu_in  = (!alu_stall && $urandom_range(0, 1) == 1)
                ? mk($urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1))) : '0;
      st_in   = (!st_stall && $urandom_range(0, 1) == 1)
                ? mk($urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1))) : '0;
    end
    cyc();
    reset = 1'b0;
    idle_inputs();
    repeat (10) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
